// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key
// code table and the row/column priority encoder.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_INIT = 4'b1110;
    localparam logic [3:0] ALL_HIGH = 4'b1111;

    // Indexed by {row, col}; rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running scan tick generator: one-cycle pulse every 2^SCAN_BITS clocks.
// Shared with the display multiplexer.
module scan_tick #(
    parameter int SCAN_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [SCAN_BITS-1:0] cnt;

    // Registered so tick is high in the cycle the counter reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt + SCAN_BITS'(1);
            tick <= &cnt;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce, key code lookup and a
// write-address generator for a small register bank.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_BITS = 16,
    parameter int DEB_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [2:0] wr_addr,
    output logic       wr_en
);

    localparam int DEB_W = $clog2(DEB_TICKS + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS);

    logic             tick;
    logic [3:0]       cols_p0, cols_p1;
    state_t           state, state_n;
    logic [3:0]       rows_n, key_n;
    logic [1:0]       row_lat, row_lat_n, col_lat, col_lat_n;
    logic [DEB_W-1:0] deb_cnt, deb_n, deb_inc;
    logic [2:0]       addr_n;
    logic             need_rel, need_rel_n;
    logic [1:0]       quiet_cnt, quiet_n;

    scan_tick #(.SCAN_BITS(SCAN_BITS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign deb_inc = deb_cnt + DEB_W'(1);

    // Stage boundary: cols is asynchronous; cols_p1 is the synchronized view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cols_p0 <= ALL_HIGH;
            cols_p1 <= ALL_HIGH;
        end else begin
            cols_p0 <= cols;
            cols_p1 <= cols_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            rows      <= ROW_INIT;
            row_lat   <= 2'd0;
            col_lat   <= 2'd0;
            deb_cnt   <= '0;
            key       <= 4'h0;
            wr_addr   <= 3'd0;
            need_rel  <= 1'b1;
            quiet_cnt <= 2'd0;
        end else begin
            state     <= state_n;
            rows      <= rows_n;
            row_lat   <= row_lat_n;
            col_lat   <= col_lat_n;
            deb_cnt   <= deb_n;
            key       <= key_n;
            wr_addr   <= addr_n;
            need_rel  <= need_rel_n;
            quiet_cnt <= quiet_n;
        end
    end

    // After reset a key still held must not be emitted: scanning is only armed
    // once a full sweep of all four rows has seen no low column.
    always_comb begin
        state_n    = state;
        rows_n     = rows;
        row_lat_n  = row_lat;
        col_lat_n  = col_lat;
        deb_n      = deb_cnt;
        key_n      = key;
        addr_n     = wr_addr;
        need_rel_n = need_rel;
        quiet_n    = quiet_cnt;
        key_valid  = 1'b0;
        wr_en      = 1'b0;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (cols_p1 == ALL_HIGH || need_rel)
                        rows_n = {rows[2:0], rows[3]};
                    if (need_rel) begin
                        if (cols_p1 == ALL_HIGH) begin
                            quiet_n = quiet_cnt + 2'd1;
                            if (quiet_cnt == 2'd3)
                                need_rel_n = 1'b0;
                        end else begin
                            quiet_n = 2'd0;
                        end
                    end else if (cols_p1 != ALL_HIGH) begin
                        row_lat_n = lowest_low(rows);
                        col_lat_n = lowest_low(cols_p1);
                        deb_n     = '0;
                        state_n   = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!cols_p1[col_lat]) begin
                        deb_n = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            key_n   = KEY_MAP[{row_lat, col_lat}];
                            state_n = EMIT;
                        end
                    end else begin
                        deb_n   = '0;
                        state_n = SCAN;
                    end
                end
            end
            EMIT: begin
                key_valid = 1'b1;
                wr_en     = 1'b1;
                addr_n    = wr_addr + 3'd1;
                deb_n     = '0;
                state_n   = RELEASE;
            end
            RELEASE: begin
                if (tick) begin
                    if (cols_p1 == ALL_HIGH) begin
                        deb_n = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            deb_n   = '0;
                            state_n = SCAN;
                        end
                    end else begin
                        deb_n = '0;
                    end
                end
            end
            default: state_n = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a behavioural keypad matrix and
// an emission scoreboard; SCAN_BITS=2, DEB_TICKS=3.
module tb_keypad_scan;

    localparam int SB      = 2;
    localparam int DT      = 3;
    localparam int TP      = 1 << SB;
    localparam int LAT_MAX = (4 + DT) * TP + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cols, rows, key;
    logic       key_valid, wr_en;
    logic [2:0] wr_addr;

    logic [15:0] pressed = '0;
    int total = 0;
    int bad = 0;
    int exp_addr = 0;
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    logic [3:0] q_key [$];
    logic [2:0] q_addr [$];
    int   long_cnt = 0;
    int   wren_bad = 0;
    logic kv_prev = 1'b0;

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
    end

    keypad_scan #(.SCAN_BITS(SB), .DEB_TICKS(DT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cols      (cols),
        .rows      (rows),
        .key       (key),
        .key_valid (key_valid),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en)
    );

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            q_key.push_back(key);
            q_addr.push_back(wr_addr);
            if (kv_prev === 1'b1) long_cnt++;
        end
        if (wr_en !== key_valid) wren_bad++;
        kv_prev = key_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_ticks(input int n);
        repeat (n * TP) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_key.delete();
        q_addr.delete();
    endtask

    // Press one key, hold it `hold` ticks past the first key_valid, release and settle.
    task automatic do_press(input int r, input int c, input int hold, output int lat);
        int cyc;
        clear_q();
        pressed[r*4+c] = 1'b1;
        lat = -1;
        cyc = 0;
        while (lat < 0 && cyc < LAT_MAX + 20) begin
            @(negedge clk);
            cyc++;
            if (key_valid === 1'b1) lat = cyc;
        end
        wait_ticks(hold);
        pressed[r*4+c] = 1'b0;
        wait_ticks(8);
    endtask

    task automatic wait_kv(input string name);
        int cyc = 0;
        while (key_valid !== 1'b1 && cyc < LAT_MAX + 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (key_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: got no key_valid within %0d cycles, required a pulse", name, cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (rows !== 4'b1110) begin bad++; $display("FAIL reset_rows: got %b want 1110", rows); end
        total++; if (key !== 4'h0) begin bad++; $display("FAIL reset_key: got %h want 0", key); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", wr_en); end
        total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", wr_addr); end
        @(negedge clk);
        rst = 1'b0;
        exp_addr = 0;
        wait_ticks(8);
    endtask

    task automatic test_first_key();
        int lat;
        logic [3:0] k;
        logic [2:0] a;
        do_press(0, 1, 6, lat);
        k = (q_key.size() > 0) ? q_key[0] : 4'hx;
        a = (q_addr.size() > 0) ? q_addr[0] : 3'hx;
        total++; if (q_key.size() != 1) begin bad++; $display("FAIL first_count: got %0d want 1", q_key.size()); end
        total++; if (k !== 4'h2) begin bad++; $display("FAIL first_key: got %h want 2", k); end
        total++; if (a !== 3'd0) begin bad++; $display("FAIL first_addr: got %0d want 0", a); end
        total++; if (lat < 1 || lat > LAT_MAX) begin bad++; $display("FAIL first_latency: got %0d want 1..%0d", lat, LAT_MAX); end
        total++; if (wr_addr !== 3'd1) begin bad++; $display("FAIL first_addr_after: got %0d want 1", wr_addr); end
        exp_addr = 1;
    endtask

    task automatic test_debounce_glitch();
        logic [3:0] target;
        int cyc;
        target = 4'b1011;
        cyc = 0;
        while (rows === target && cyc < 40) begin @(posedge clk); #1; cyc++; end
        while (rows !== target && cyc < 40) begin @(posedge clk); #1; cyc++; end
        total++;
        if (rows !== target) begin bad++; $display("FAIL glitch_sync: got rows %b want %b", rows, target); end
        clear_q();
        pressed[2*4+3] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        total++; if (rows !== target) begin bad++; $display("FAIL glitch_held: got rows %b want %b", rows, target); end
        pressed[2*4+3] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        total++; if (rows === target) begin bad++; $display("FAIL glitch_resume: got rows %b want not %b", rows, target); end
        wait_ticks(6);
        total++; if (q_key.size() != 0) begin bad++; $display("FAIL glitch_no_emit: got %0d emissions want 0", q_key.size()); end
    endtask

    task automatic test_long_hold();
        logic [3:0] k;
        logic [2:0] a;
        clear_q();
        pressed[1*4+1] = 1'b1;
        wait_kv("long");
        wait_ticks(10);
        pressed[2*4+2] = 1'b1;
        wait_ticks(10);
        pressed[2*4+2] = 1'b0;
        wait_ticks(28);
        pressed[1*4+1] = 1'b0;
        wait_ticks(8);
        k = (q_key.size() > 0) ? q_key[0] : 4'hx;
        a = (q_addr.size() > 0) ? q_addr[0] : 3'hx;
        total++; if (q_key.size() != 1) begin bad++; $display("FAIL long_count: got %0d want 1", q_key.size()); end
        total++; if (k !== 4'h5) begin bad++; $display("FAIL long_key: got %h want 5", k); end
        total++; if (a !== 3'(exp_addr)) begin bad++; $display("FAIL long_addr: got %0d want %0d", a, exp_addr); end
        exp_addr = (exp_addr + 1) % 8;
    endtask

    task automatic test_two_cols();
        logic [3:0] k;
        clear_q();
        pressed[3*4+0] = 1'b1;
        pressed[3*4+2] = 1'b1;
        wait_kv("twocol");
        wait_ticks(4);
        pressed[3*4+0] = 1'b0;
        pressed[3*4+2] = 1'b0;
        wait_ticks(8);
        k = (q_key.size() > 0) ? q_key[0] : 4'hx;
        total++; if (q_key.size() != 1) begin bad++; $display("FAIL twocol_count: got %0d want 1", q_key.size()); end
        total++; if (k !== 4'hE) begin bad++; $display("FAIL twocol_key: got %h want E", k); end
        exp_addr = (exp_addr + 1) % 8;
    endtask

    task automatic test_back_to_back();
        int r, c, lat;
        logic [3:0] k;
        logic [2:0] a;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 9; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            do_press(r, c, $urandom_range(2, 6), lat);
            k = (q_key.size() > 0) ? q_key[0] : 4'hx;
            a = (q_addr.size() > 0) ? q_addr[0] : 3'hx;
            total++; if (q_key.size() != 1) begin bad++; $display("FAIL seq%0d_count: got %0d want 1", i, q_key.size()); end
            total++; if (k !== kmap[r*4+c]) begin bad++; $display("FAIL seq%0d_key: got %h want %h", i, k, kmap[r*4+c]); end
            total++; if (a !== 3'(i % 8)) begin bad++; $display("FAIL seq%0d_addr: got %0d want %0d", i, a, i % 8); end
            total++; if (lat < 1 || lat > LAT_MAX) begin bad++; $display("FAIL seq%0d_latency: got %0d want 1..%0d", i, lat, LAT_MAX); end
        end
        total++; if (wr_addr !== 3'd1) begin bad++; $display("FAIL seq_addr_after: got %0d want 1", wr_addr); end
        total++; if (long_cnt != 0) begin bad++; $display("FAIL pulse_width: got %0d long pulses want 0", long_cnt); end
        total++; if (wren_bad != 0) begin bad++; $display("FAIL wren_align: got %0d misaligned cycles want 0", wren_bad); end
        exp_addr = 1;
    endtask

    task automatic test_reset_release();
        int lat;
        logic [3:0] k;
        logic [2:0] a;
        clear_q();
        pressed[3*4+2] = 1'b1;
        wait_kv("rstrel");
        total++; if (key !== 4'hF) begin bad++; $display("FAIL rstrel_key: got %h want F", key); end
        wait_ticks(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (rows !== 4'b1110) begin bad++; $display("FAIL rstrel_rows: got %b want 1110", rows); end
        total++; if (key !== 4'h0) begin bad++; $display("FAIL rstrel_key0: got %h want 0", key); end
        total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL rstrel_addr: got %0d want 0", wr_addr); end
        total++; if (key_valid !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL rstrel_strobes: got kv=%b we=%b want 0 0", key_valid, wr_en); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_q();
        wait_ticks(30);
        total++; if (q_key.size() != 0) begin bad++; $display("FAIL rstrel_held: got %0d emissions want 0", q_key.size()); end
        pressed[3*4+2] = 1'b0;
        wait_ticks(8);
        do_press(3, 2, 4, lat);
        k = (q_key.size() > 0) ? q_key[0] : 4'hx;
        a = (q_addr.size() > 0) ? q_addr[0] : 3'hx;
        total++; if (q_key.size() != 1 || k !== 4'hF) begin bad++; $display("FAIL rstrel_repress: got %0d emissions key %h want 1 key F", q_key.size(), k); end
        total++; if (a !== 3'd0) begin bad++; $display("FAIL rstrel_repress_addr: got %0d want 0", a); end
    endtask

    initial begin
        test_reset();
        test_first_key();
        test_debounce_glitch();
        test_long_hold();
        test_two_cols();
        test_back_to_back();
        test_reset_release();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
